// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with architectural HI/LO registers.
// Multiply and divide results appear after a fixed number of busy cycles.
// HI/LO change only on the completing edge, or on the issuing edge for MTHI/MTLO.
// Optional feature: define MDU_MADD_EN to add MADD/MSUB (ops 6/7), which
// accumulate into {HI,LO}. Without it, ops 6/7 are ignored.
module mdu_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

  // The counter is loaded with latency-1 so the completing edge sees zero.
  localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               mul_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] mul_result;

  logic               div_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   uquot, urem;
  logic [WIDTH-1:0]   quot, rem;

  // Product of the captured operands. Extending both to 2*WIDTH (by sign or
  // by zero) lets one multiplier serve signed and unsigned, modulo 2^(2*WIDTH).
  always_comb begin
    mul_signed = (op_q != OP_MULTU);
    ext_a      = {{WIDTH{mul_signed & a_q[WIDTH-1]}}, a_q};
    ext_b      = {{WIDTH{mul_signed & b_q[WIDTH-1]}}, b_q};
    product    = ext_a * ext_b;
`ifdef MDU_MADD_EN
    // Accumulation uses the HI/LO values present at completion.
    case (op_q)
      OP_MADD: mul_result = {hi_q, lo_q} + product;
      OP_MSUB: mul_result = {hi_q, lo_q} - product;
      default: mul_result = product;
    endcase
`else
    mul_result = product;
`endif
  end

  // Quotient and remainder of the captured operands. The division is done on
  // magnitudes, then the signs are restored: the quotient truncates toward
  // zero and the remainder follows the dividend. The overflow case
  // (min / -1) falls out as quotient = min and remainder = 0.
  always_comb begin
    div_signed = (op_q == OP_DIV);
    a_neg      = div_signed & a_q[WIDTH-1];
    b_neg      = div_signed & b_q[WIDTH-1];
    mag_a      = a_neg ? -a_q : a_q;
    mag_b      = b_neg ? -b_q : b_q;
    uquot      = mag_a / mag_b;
    urem       = mag_a % mag_b;
    quot       = (a_neg ^ b_neg) ? -uquot : uquot;
    rem        = a_neg ? -urem : urem;
    if (b_q == '0) begin
      quot = '1;
      rem  = a_q;
    end
  end

  // Control path: issue only from IDLE, count down while busy, and commit
  // HI/LO on the edge that returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (Op)
            OP_MULT, OP_MULTU: begin
              state_d = S_MUL;
              cnt_d   = MUL_LOAD;
              op_d    = Op;
              a_d     = A;
              b_d     = B;
            end
            OP_DIV, OP_DIVU: begin
              state_d = S_DIV;
              cnt_d   = DIV_LOAD;
              op_d    = Op;
              a_d     = A;
              b_d     = B;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB: begin
              state_d = S_MUL;
              cnt_d   = MUL_LOAD;
              op_d    = Op;
              a_d     = A;
              b_d     = B;
            end
`endif
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          state_d      = S_IDLE;
          {hi_d, lo_d} = mul_result;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DIV: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          hi_d    = rem;
          lo_d    = quot;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset also clears HI/LO and abandons any operation.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = (state_q != S_IDLE);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed vectors plus hand-written sequences for mdu_iter.
// Build with MDU_MADD_EN defined to exercise MADD/MSUB; otherwise ops 6/7
// are expected to be ignored.
module tb_mdu_iter;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int failures;

  localparam int BUSY_LIMIT = 40;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  mdu_iter #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  // Free-running clock, 10 time units per period.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One comparison: count it and report a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Counts busy negedges until Busy drops, flagging any HI/LO change meanwhile.
  task automatic waitIdle(input string name, input logic [31:0] held_hi, input logic [31:0] held_lo,
                          output int cycles);
    int changes;
    cycles  = 0;
    changes = 0;
    while (Busy && cycles < BUSY_LIMIT) begin
      cycles++;
      if (HI !== held_hi || LO !== held_lo) changes++;
      @(negedge Clk);
    end
    if (cycles >= BUSY_LIMIT) checkOutput({name, " busy timeout"}, 64'(Busy), 64'd0);
    checkOutput({name, " hi/lo stable while busy"}, 64'(changes), 64'd0);
  endtask

  // Drives one Start pulse at a negedge, then scrambles the inputs so the
  // result depends only on what was captured.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(negedge Clk);
    Start = 1'b0;
    Op    = 3'd7 - op;
    A     = ~a;
    B     = ~b;
  endtask

  // Applies one table record and compares latency and final HI/LO.
  task automatic applyStimulus(input vec_t v);
    logic [31:0] held_hi;
    logic [31:0] held_lo;
    int          cycles;
    @(negedge Clk);
    held_hi = HI;
    held_lo = LO;
    issue(v.op, v.a, v.b);
    if (v.cycles == 0) begin
      cycles = 0;
    end else begin
      waitIdle(v.name, held_hi, held_lo, cycles);
    end
    checkOutput({v.name, " busy cycles"}, 64'(cycles), 64'(v.cycles));
    checkOutput({v.name, " HI"}, 64'(HI), 64'(v.hi));
    checkOutput({v.name, " LO"}, 64'(LO), 64'(v.lo));
  endtask

  initial begin
    int          cycles;
    logic [31:0] held_hi;
    logic [31:0] held_lo;

    checks   = 0;
    failures = 0;

    vecs[0]  = '{"mult -2*3",         3'd0, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{"multu max*max",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{"mult 7*-5",         3'd0, 32'd7,        32'hFFFFFFFB, 5,  32'hFFFFFFFF, 32'hFFFFFFDD};
    vecs[3]  = '{"div -7/2",          3'd2, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{"divu 100/7",        3'd3, 32'd100,      32'd7,        10, 32'd2,        32'd14};
    vecs[5]  = '{"div 7/-2",          3'd2, 32'd7,        32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD};
    vecs[6]  = '{"divu 5/0",          3'd3, 32'd5,        32'd0,        10, 32'd5,        32'hFFFFFFFF};
    vecs[7]  = '{"div overflow",      3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0,        32'h80000000};
    vecs[8]  = '{"divu big/2",        3'd3, 32'hFFFFFFF9, 32'd2,        10, 32'd1,        32'h7FFFFFFC};
    vecs[9]  = '{"mthi",              3'd4, 32'hDEADBEEF, 32'd9,        0,  32'hDEADBEEF, 32'h7FFFFFFC};
    vecs[10] = '{"mtlo",              3'd5, 32'hCAFEF00D, 32'd9,        0,  32'hDEADBEEF, 32'hCAFEF00D};
    vecs[11] = '{"div -8/0",          3'd2, 32'hFFFFFFF8, 32'd0,        10, 32'hFFFFFFF8, 32'hFFFFFFFF};

    Rst   = 1'b1;
    Start = 1'b0;
    Op    = 3'd0;
    A     = '0;
    B     = '0;

    // Reset state, then a Start on the very first edge after release.
    repeat (2) @(negedge Clk);
    checkOutput("reset Busy", 64'(Busy), 64'd0);
    checkOutput("reset HI", 64'(HI), 64'd0);
    checkOutput("reset LO", 64'(LO), 64'd0);
    Rst = 1'b0;
    issue(3'd4, 32'h0000A5A5, 32'd0);
    checkOutput("first edge mthi HI", 64'(HI), 64'h0000A5A5);
    checkOutput("first edge mthi Busy", 64'(Busy), 64'd0);

    // Directed table.
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // A DIV Start pulsed mid-MULTU must be ignored.
    @(negedge Clk);
    held_hi = HI;
    held_lo = LO;
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge Clk);
    Start = 1'b1;
    Op    = 3'd2;
    A     = 32'd1;
    B     = 32'd1;
    @(negedge Clk);
    Start = 1'b0;
    waitIdle("multu with restart", held_hi, held_lo, cycles);
    checkOutput("multu with restart busy cycles", 64'(cycles + 2), 64'd5);
    checkOutput("multu with restart HI", 64'(HI), 64'hFFFFFFFE);
    checkOutput("multu with restart LO", 64'(LO), 64'h00000001);
    repeat (3) @(negedge Clk);
    checkOutput("ignored div stays idle", 64'(Busy), 64'd0);
    checkOutput("ignored div LO", 64'(LO), 64'h00000001);

    // Start on the edge Busy falls is ignored; held one more cycle it issues.
    issue(3'd0, 32'd2, 32'd3);
    repeat (4) @(negedge Clk);
    checkOutput("last busy cycle", 64'(Busy), 64'd1);
    Start = 1'b1;
    Op    = 3'd5;
    A     = 32'h55;
    @(negedge Clk);
    checkOutput("fall edge Busy", 64'(Busy), 64'd0);
    checkOutput("fall edge HI", 64'(HI), 64'd0);
    checkOutput("fall edge LO not mtlo", 64'(LO), 64'd6);
    @(negedge Clk);
    Start = 1'b0;
    checkOutput("next cycle mtlo LO", 64'(LO), 64'h55);

    // Reset during busy cycle 3 of a DIV, then MTLO right after release.
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    repeat (2) @(negedge Clk);
    checkOutput("div before reset Busy", 64'(Busy), 64'd1);
    Rst = 1'b1;
    #1;
    checkOutput("async reset Busy", 64'(Busy), 64'd0);
    checkOutput("async reset HI", 64'(HI), 64'd0);
    checkOutput("async reset LO", 64'(LO), 64'd0);
    @(negedge Clk);
    Rst = 1'b0;
    issue(3'd5, 32'h1234, 32'd0);
    checkOutput("post reset mtlo LO", 64'(LO), 64'h1234);
    checkOutput("post reset mtlo Busy", 64'(Busy), 64'd0);
    repeat (12) @(negedge Clk);
    checkOutput("no residue Busy", 64'(Busy), 64'd0);
    checkOutput("no residue HI", 64'(HI), 64'd0);
    checkOutput("no residue LO", 64'(LO), 64'h1234);

    // Multiply-accumulate ops, or their absence.
    issue(3'd4, 32'd0, 32'd0);
    issue(3'd5, 32'hFFFFFFFF, 32'd0);
    held_hi = HI;
    held_lo = LO;
    issue(3'd6, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    waitIdle("madd", held_hi, held_lo, cycles);
    checkOutput("madd busy cycles", 64'(cycles), 64'd5);
    checkOutput("madd HI", 64'(HI), 64'd1);
    checkOutput("madd LO", 64'(LO), 64'd0);
    held_hi = HI;
    held_lo = LO;
    issue(3'd7, 32'd2, 32'd3);
    waitIdle("msub", held_hi, held_lo, cycles);
    checkOutput("msub busy cycles", 64'(cycles), 64'd5);
    checkOutput("msub HI", 64'(HI), 64'd0);
    checkOutput("msub LO", 64'(LO), 64'hFFFFFFFA);
`else
    checkOutput("op6 no-op Busy", 64'(Busy), 64'd0);
    checkOutput("op6 no-op HI", 64'(HI), 64'd0);
    checkOutput("op6 no-op LO", 64'(LO), 64'hFFFFFFFF);
    issue(3'd7, 32'd2, 32'd3);
    checkOutput("op7 no-op Busy", 64'(Busy), 64'd0);
    checkOutput("op7 no-op HI", 64'(HI), 64'd0);
    checkOutput("op7 no-op LO", 64'(LO), 64'hFFFFFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
